bus_monitor_multi: RTL and testbench
====================================

BUS_MONITOR_MULTI -- requirements
Module: bus_monitor_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored master/slave channels (1..16).
REQ-002 Parameter ADDR_W, default 16, width of each channel address.
REQ-003 Parameter TIMEOUT, default 1000, cycles a strobe may stay unacknowledged before a timeout (2..2^CNT_W-1).
REQ-004 Parameter CNT_W, default 16, width of the timeout counter and the error counter.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 bus_cyc  in  NUM_CH  per-channel bus cycle valid.
REQ-008 bus_stb  in  NUM_CH  per-channel strobe.
REQ-009 bus_ack  in  NUM_CH  per-channel slave acknowledge.
REQ-010 bus_adr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 to_ack  out  NUM_CH  synthetic acknowledge driven to master i on timeout.
REQ-012 to_err  out  NUM_CH  error qualifier, asserted together with to_ack.
REQ-013 fault_valid  out  1  a captured fault is held.
REQ-014 fault_ch  out  4  channel index of the captured fault.
REQ-015 fault_adr  out  ADDR_W  address of the captured fault.
REQ-016 fault_clear  in  1  single-cycle pulse releasing the fault capture.
REQ-017 err_count  out  CNT_W  total timeouts since reset, saturating.

Function
REQ-018 Each channel SHALL run an FSM with states IDLE, WAIT, ABORT.
REQ-019 IDLE -> WAIT when cyc&stb&!ack; the counter loads 1 on that edge.
REQ-020 In WAIT, each cycle with cyc&stb&!ack SHALL increment the counter.
REQ-021 WAIT -> IDLE when ack is seen, or when cyc or stb drops; the counter clears.
REQ-022 WAIT -> ABORT when the counter equals TIMEOUT and ack is low in that cycle.
- to_ack[i] and to_err[i] are registered and asserted for exactly one cycle, the cycle after the transition.
REQ-023 A real ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: no timeout, return to IDLE.
REQ-024 ABORT SHALL wait until stb is low, then enter IDLE.
- No second timeout is raised for the same strobe.
REQ-025 A strobe acknowledged in its first cycle SHALL never leave IDLE.
REQ-026 Fault capture records channel and address at the timeout cycle; it is then held until fault_clear.
- When fault_valid is set, later faults are not captured but still counted.
REQ-027 Simultaneous timeouts on several channels: the lowest channel index SHALL be captured.
REQ-028 fault_clear coincident with a new timeout: the new fault SHALL be captured (fault_valid stays 1).
REQ-029 err_count adds the number of channels timing out in a cycle.
- It saturates at 2^CNT_W-1 and never wraps.

Reset
REQ-030 While reset is high, the following SHALL be forced on the next edge:
- all FSMs to IDLE;
- counters, to_ack, to_err, fault_valid, fault_ch, fault_adr and err_count to 0.
REQ-031 Reset during WAIT or ABORT SHALL abort without emitting to_ack.
- Monitoring restarts on the first cycle after reset deasserts.

Structure
REQ-032 Package bus_monitor_pkg SHALL hold the FSM state encoding (IDLE=0, WAIT=1, ABORT=2) and the default parameter constants.
REQ-033 Per-channel FSM and counter SHALL be a sub-module bus_monitor_ch.
- It is instantiated NUM_CH times.
- The top level holds only the fault-capture priority logic and err_count.

Verification
REQ-034 Ch0 strobe, ack after 5 cycles -> no to_ack; err_count=0; fault_valid=0.
REQ-035 TIMEOUT=8, ch2 strobe held at adr 0x1234 with no ack -> to_ack[2]=to_err[2]=1 for one cycle, 9 cycles after strobe; fault_ch=2; fault_adr=0x1234; err_count=1.
REQ-036 TIMEOUT=8, ack on ch1 exactly in the counter=8 cycle -> no timeout; err_count unchanged.
REQ-037 Ch1 and ch3 time out in the same cycle -> fault_ch=1; err_count increases by 2.
REQ-038 CNT_W=4 with 20 forced timeouts -> err_count=15; fault_clear pulsed with a new ch0 timeout -> fault_valid=1, fault_ch=0.
REQ-039 Reset asserted mid-WAIT on ch0 -> no to_ack; all outputs 0.
- A new strobe after reset times out normally.

Source files
------------

// File: rtl/bus_monitor_pkg.sv
// ============================================================================
//  Module   : bus_monitor_pkg
//  Purpose  : Shared state encoding and default parameters for the bus monitor
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_monitor_pkg;

    localparam int C_DEF_NUM_CH  = 4;
    localparam int C_DEF_ADDR_W  = 16;
    localparam int C_DEF_TIMEOUT = 1000;
    localparam int C_DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_monitor_ch.sv
// ============================================================================
//  Module   : bus_monitor_ch
//  Purpose  : Single-channel strobe watchdog raising a one-cycle synthetic
//             error acknowledge when a strobe stalls past TIMEOUT cycles
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_monitor_ch
    import bus_monitor_pkg::*;
#(
    parameter int TIMEOUT = C_DEF_TIMEOUT,
    parameter int CNT_W   = C_DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cyc,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_to_ack,
    output logic o_to_err,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_to_ack;
    logic             w_stall;

    assign w_stall = i_cyc & i_stb & ~i_ack;

    // Combinational event so the top can capture the address on the abort edge
    assign o_timeout = (r_state == WAIT) && w_stall && (r_cnt == C_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_to_ack <= 1'b0;
        end else begin
            r_to_ack <= o_timeout;
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!w_stall) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_state <= ABORT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ABORT: begin
                    if (!i_stb) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_to_ack = r_to_ack;
    assign o_to_err = r_to_ack;

endmodule

`default_nettype wire

// File: rtl/bus_monitor_multi.sv
// ============================================================================
//  Module   : bus_monitor_multi
//  Purpose  : Multi-channel bus timeout monitor with lowest-index fault
//             capture and a saturating error counter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_monitor_multi
    import bus_monitor_pkg::*;
#(
    parameter int NUM_CH  = C_DEF_NUM_CH,
    parameter int ADDR_W  = C_DEF_ADDR_W,
    parameter int TIMEOUT = C_DEF_TIMEOUT,
    parameter int CNT_W   = C_DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        bus_cyc,
    input  logic [NUM_CH-1:0]        bus_stb,
    input  logic [NUM_CH-1:0]        bus_ack,
    input  logic [NUM_CH*ADDR_W-1:0] bus_adr,
    output logic [NUM_CH-1:0]        to_ack,
    output logic [NUM_CH-1:0]        to_err,
    output logic                     fault_valid,
    output logic [3:0]               fault_ch,
    output logic [ADDR_W-1:0]        fault_adr,
    input  logic                     fault_clear,
    output logic [CNT_W-1:0]         err_count
);

    localparam int               C_SUM_W   = CNT_W + 5;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0]  w_timeout;
    logic               w_hit;
    logic [3:0]         w_sel;
    logic [ADDR_W-1:0]  w_adr;
    logic [C_SUM_W-1:0] w_sum;
    logic [CNT_W-1:0]   w_err_next;

    logic               r_fault_valid;
    logic [3:0]         r_fault_ch;
    logic [ADDR_W-1:0]  r_fault_adr;
    logic [CNT_W-1:0]   r_err_count;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            bus_monitor_ch #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_ch (
                .clk       (clk),
                .rst       (reset),
                .i_cyc     (bus_cyc[gi]),
                .i_stb     (bus_stb[gi]),
                .i_ack     (bus_ack[gi]),
                .o_to_ack  (to_ack[gi]),
                .o_to_err  (to_err[gi]),
                .o_timeout (w_timeout[gi])
            );
        end
    endgenerate

    // Scan high to low so the lowest timing-out channel is the last write
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        w_adr = '0;
        w_sum = C_SUM_W'(r_err_count);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_sum = w_sum + C_SUM_W'(w_timeout[i]);
            if (w_timeout[i]) begin
                w_hit = 1'b1;
                w_sel = 4'(i);
                w_adr = bus_adr[i*ADDR_W +: ADDR_W];
            end
        end
        w_err_next = (w_sum > C_SUM_W'(C_CNT_MAX)) ? C_CNT_MAX : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_valid <= 1'b0;
            r_fault_ch    <= '0;
            r_fault_adr   <= '0;
            r_err_count   <= '0;
        end else begin
            // A clear coinciding with a new timeout hands the slot to the new fault
            if (w_hit && (!r_fault_valid || fault_clear)) begin
                r_fault_valid <= 1'b1;
                r_fault_ch    <= w_sel;
                r_fault_adr   <= w_adr;
            end else if (fault_clear) begin
                r_fault_valid <= 1'b0;
            end
            r_err_count <= w_err_next;
        end
    end

    assign fault_valid = r_fault_valid;
    assign fault_ch    = r_fault_ch;
    assign fault_adr   = r_fault_adr;
    assign err_count   = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_bus_monitor_multi.sv
// ============================================================================
//  Module   : tb_bus_monitor_multi
//  Purpose  : Directed and randomized self-checking bench for bus_monitor_multi
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_monitor_multi;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int C_MAX   = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        bus_cyc, bus_stb, bus_ack;
    logic [NUM_CH*ADDR_W-1:0] bus_adr;
    logic                     fault_clear;
    logic [NUM_CH-1:0]        to_ack, to_err;
    logic                     fault_valid;
    logic [3:0]               fault_ch;
    logic [ADDR_W-1:0]        fault_adr;
    logic [CNT_W-1:0]         err_count;

    always #5 clk = ~clk;

    bus_monitor_multi #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_cyc     (bus_cyc),
        .bus_stb     (bus_stb),
        .bus_ack     (bus_ack),
        .bus_adr     (bus_adr),
        .to_ack      (to_ack),
        .to_err      (to_err),
        .fault_valid (fault_valid),
        .fault_ch    (fault_ch),
        .fault_adr   (fault_adr),
        .fault_clear (fault_clear),
        .err_count   (err_count)
    );

    // Reference: a strobe stalled for TIMEOUT+1 consecutive cycles times out once
    int                stall   [NUM_CH];
    bit                aborted [NUM_CH];
    logic [NUM_CH-1:0] exp_to;
    logic              exp_fv;
    logic [3:0]        exp_fch;
    logic [ADDR_W-1:0] exp_fadr;
    int                exp_err;
    int                tests = 0;
    int                fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int n;
        int first;
        n     = 0;
        first = -1;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stall[c]   = 0;
                aborted[c] = 1'b0;
            end
            exp_to   = '0;
            exp_fv   = 1'b0;
            exp_fch  = '0;
            exp_fadr = '0;
            exp_err  = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                exp_to[c] = 1'b0;
                if (aborted[c]) begin
                    if (!bus_stb[c]) aborted[c] = 1'b0;
                end else if (bus_cyc[c] && bus_stb[c] && !bus_ack[c]) begin
                    if (stall[c] == TIMEOUT) begin
                        exp_to[c]  = 1'b1;
                        aborted[c] = 1'b1;
                        stall[c]   = 0;
                        n++;
                        if (first < 0) first = c;
                    end else begin
                        stall[c]++;
                    end
                end else begin
                    stall[c] = 0;
                end
            end
            if (first >= 0 && (!exp_fv || fault_clear)) begin
                exp_fv   = 1'b1;
                exp_fch  = 4'(first);
                exp_fadr = bus_adr[first*ADDR_W +: ADDR_W];
            end else if (fault_clear) begin
                exp_fv = 1'b0;
            end
            exp_err = (exp_err + n > C_MAX) ? C_MAX : exp_err + n;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("to_ack", 32'(to_ack), 32'(exp_to));
        check("to_err", 32'(to_err), 32'(exp_to));
        check("fault_valid", 32'(fault_valid), 32'(exp_fv));
        if (exp_fv) begin
            check("fault_ch", 32'(fault_ch), 32'(exp_fch));
            check("fault_adr", 32'(fault_adr), 32'(exp_fadr));
        end
        check("err_count", 32'(err_count), 32'(exp_err));
    endtask

    task automatic set_ch(input int ch, input logic c, input logic s, input logic a);
        bus_cyc[ch] = c;
        bus_stb[ch] = s;
        bus_ack[ch] = a;
    endtask

    task automatic idle_all();
        bus_cyc     = '0;
        bus_stb     = '0;
        bus_ack     = '0;
        fault_clear = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            stall[c]   = 0;
            aborted[c] = 1'b0;
        end
        exp_to = '0; exp_fv = 1'b0; exp_fch = '0; exp_fadr = '0; exp_err = 0;
        reset   = 1'b1;
        bus_adr = '0;
        idle_all();
        repeat (3) tick();
        check("reset_err", 32'(err_count), 32'd0);
        check("reset_fv", 32'(fault_valid), 32'd0);
        reset = 1'b0;
        tick();

        // Ack after five stalled cycles: no timeout
        set_ch(0, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        bus_ack[0] = 1'b1;
        tick();
        idle_all();
        tick();
        check("ack5_err", 32'(err_count), 32'd0);
        check("ack5_fv", 32'(fault_valid), 32'd0);

        // Ch2 held without ack: pulse lands nine cycles after the strobe
        bus_adr[2*ADDR_W +: ADDR_W] = 16'h1234;
        set_ch(2, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("ch2_to_ack", 32'(to_ack[2]), 32'(k == 9));
        end
        check("ch2_fault_ch", 32'(fault_ch), 32'd2);
        check("ch2_fault_adr", 32'(fault_adr), 32'h1234);
        check("ch2_err", 32'(err_count), 32'd1);
        idle_all();
        tick();

        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("clear_fv", 32'(fault_valid), 32'd0);

        // Ack arriving exactly when the counter reaches TIMEOUT wins
        set_ch(1, 1'b1, 1'b1, 1'b0);
        repeat (8) tick();
        bus_ack[1] = 1'b1;
        tick();
        idle_all();
        tick();
        check("ack_race_to", 32'(to_ack), 32'd0);
        check("ack_race_err", 32'(err_count), 32'd1);

        // Simultaneous ch1/ch3 timeouts: lowest index captured, count +2
        bus_adr[1*ADDR_W +: ADDR_W] = 16'hA001;
        bus_adr[3*ADDR_W +: ADDR_W] = 16'hA003;
        set_ch(1, 1'b1, 1'b1, 1'b0);
        set_ch(3, 1'b1, 1'b1, 1'b0);
        repeat (9) tick();
        check("dual_to", 32'(to_ack), 32'b1010);
        check("dual_fault_ch", 32'(fault_ch), 32'd1);
        check("dual_err", 32'(err_count), 32'd3);
        idle_all();
        tick();

        // Twenty further timeouts saturate the counter
        for (int r = 0; r < 20; r++) begin
            set_ch(3, 1'b1, 1'b1, 1'b0);
            repeat (9) tick();
            idle_all();
            tick();
        end
        check("sat_err", 32'(err_count), 32'd15);

        // Clear coincident with a new ch0 timeout keeps the fault captured
        bus_adr[0 +: ADDR_W] = 16'hBEEF;
        set_ch(0, 1'b1, 1'b1, 1'b0);
        repeat (8) tick();
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("clr_hit_fv", 32'(fault_valid), 32'd1);
        check("clr_hit_ch", 32'(fault_ch), 32'd0);
        idle_all();
        tick();

        // Reset mid-WAIT aborts silently; a fresh strobe then times out
        set_ch(0, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait_to", 32'(to_ack), 32'd0);
        check("rst_wait_err", 32'(err_count), 32'd0);
        check("rst_wait_fv", 32'(fault_valid), 32'd0);
        idle_all();
        tick();
        set_ch(0, 1'b1, 1'b1, 1'b0);
        repeat (9) tick();
        check("post_rst_to", 32'(to_ack[0]), 32'd1);
        check("post_rst_err", 32'(err_count), 32'd1);
        idle_all();
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(9) == 0) bus_stb[c] = ~bus_stb[c];
                bus_cyc[c] = bus_stb[c] | ($urandom_range(3) == 0);
                bus_ack[c] = ($urandom_range(11) == 0);
                if ($urandom_range(7) == 0) bus_adr[c*ADDR_W +: ADDR_W] = 16'($urandom);
            end
            fault_clear = ($urandom_range(15) == 0);
            reset       = ($urandom_range(299) == 0);
            tick();
        end
        reset = 1'b0;
        idle_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
